// File: rtl/mul8_shift_add.sv
// Sequential unsigned shift-and-add multiplier with a START/BUSY/DONE handshake.
// Optional MUL_EARLY_EXIT_EN ends the run once the remaining multiplier bits are zero.
module mul8_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [WIDTH-1:0] mplr_sh;
  logic           last_step;

  assign mplr_sh = mplr_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits all zero: further steps add nothing.
  assign last_step = (cnt_q == LAST) || (mplr_sh == '0);
`else
  assign last_step = (cnt_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          prod_d  = '0;
          mcand_d = {{WIDTH{1'b0}}, A};
          mplr_d  = B;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (mplr_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_sh;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign P    = prod_q;

endmodule

// File: tb/tb_mul8_shift_add.sv
// Directed table-driven bench for mul8_shift_add.
// Expected latency tracks MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_mul8_shift_add;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        BUSY;
  logic        DONE;
  logic [15:0] P;

  int n_cmp = 0;
  int n_bad = 0;

  mul8_shift_add #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .A    (A),
    .B    (B),
    .BUSY (BUSY),
    .DONE (DONE),
    .P    (P)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = i + 1;
    end
`ifndef MUL_EARLY_EXIT_EN
    n = 8;
`endif
    return n;
  endfunction

  // Start one op; report cycle index of DONE (relative to accepting edge),
  // number of BUSY cycles before DONE, P at DONE and P right after accept.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcnt,
                       output logic [15:0] p, output logic [15:0] p0);
    @(negedge CLK);
    START = 1'b1;
    A = a;
    B = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = ~a;
    B = ~b;
    lat = -1;
    bcnt = 0;
    p = '0;
    p0 = '0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (j == 0) p0 = P;
      if (DONE) begin
        lat = j;
        p = P;
        break;
      end
      if (BUSY) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, d1, d2;
    logic [15:0] p, p0;

    vecs[0]  = '{8'd13,  8'd11,  16'h008F};
    vecs[1]  = '{8'd255, 8'd255, 16'hFE01};
    vecs[2]  = '{8'd0,   8'd200, 16'd0};
    vecs[3]  = '{8'd200, 8'd0,   16'd0};
    vecs[4]  = '{8'd50,  8'd3,   16'd150};
    vecs[5]  = '{8'd7,   8'd9,   16'd63};
    vecs[6]  = '{8'd1,   8'd1,   16'd1};
    vecs[7]  = '{8'd128, 8'd2,   16'd256};
    vecs[8]  = '{8'd170, 8'd85,  16'd14450};
    vecs[9]  = '{8'd1,   8'd255, 16'd255};
    vecs[10] = '{8'd255, 8'd128, 16'd32640};
    vecs[11] = '{8'd3,   8'd5,   16'd15};

    RST_N = 1'b0;
    START = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge CLK);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_p", int'(P), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, bcnt, p, p0);
      chk($sformatf("v%0d_p_cleared", i), int'(p0), 0);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].b));
      chk($sformatf("v%0d_busy_cycles", i), bcnt, exp_lat(vecs[i].b));
      chk($sformatf("v%0d_product", i), int'(p), int'(vecs[i].p));
      @(negedge CLK);
      chk($sformatf("v%0d_done_pulse", i), int'(DONE), 0);
      repeat (2) @(negedge CLK);
      chk($sformatf("v%0d_p_hold", i), int'(P), int'(vecs[i].p));
    end

    // START pulse while busy must be ignored
    @(negedge CLK);
    START = 1'b1;
    A = 8'd7;
    B = 8'd9;
    @(posedge CLK);
    #1;
    START = 1'b0;
    dcnt = 0;
    d1 = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (DONE) begin
        dcnt++;
        if (d1 < 0) begin
          d1 = j;
          chk("ign_product", int'(P), 63);
        end
      end
      if (j == 2) begin
        START = 1'b1;
        A = 8'd1;
        B = 8'd1;
      end else if (j == 3) begin
        START = 1'b0;
      end
    end
    chk("ign_latency", d1, exp_lat(8'd9));
    chk("ign_done_count", dcnt, 1);
    chk("ign_p_final", int'(P), 63);

    // START held high: back-to-back period of latency+2
    @(negedge CLK);
    START = 1'b1;
    A = 8'd2;
    B = 8'd3;
    @(posedge CLK);
    #1;
    d1 = -1;
    d2 = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (DONE) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) begin
          d2 = j;
          START = 1'b0;
        end
      end
    end
    chk("b2b_first", d1, exp_lat(8'd3));
    chk("b2b_second", d2, 2 * exp_lat(8'd3) + 2);
    chk("b2b_product", int'(P), 6);

    // Asynchronous reset mid-operation
    @(negedge CLK);
    START = 1'b1;
    A = 8'd100;
    B = 8'd100;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_p", int'(P), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_op(8'd3, 8'd5, lat, bcnt, p, p0);
    chk("rst_after_latency", lat, exp_lat(8'd5));
    chk("rst_after_product", int'(p), 15);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
